datapath_controller: RTL and testbench

- Multi-cycle fetch/decode/execute/writeback controller directly upstream of the 8x4-bit register file.
- Fetches 12-bit instructions from instruction memory over a req/valid handshake and drives the register file read addresses.
- Computes results with an internal 4-bit ALU and issues single-cycle register-file writes.
- Owns the program counter, instruction register, and Z/C flags.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/datapath_controller_if.sv | 33 +++
 rtl/alu4.sv | 35 +++
 rtl/datapath_controller.sv | 134 +++++++++++++
 tb/tb_datapath_controller.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 4-bit datapath controller: opcodes, FSM states,
// instruction field positions and fixed widths.
package cpu_pkg;

    localparam int ISA_DATA_W  = 4;
    localparam int ISA_INSTR_W = 12;

    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 9;
    localparam int RD_MSB  = 8;
    localparam int RD_LSB  = 6;
    localparam int RA_MSB  = 5;
    localparam int RA_LSB  = 3;
    localparam int RB_MSB  = 2;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_LOADI = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_AND   = 3'd3,
        OP_OR    = 3'd4,
        OP_MOV   = 3'd5,
        OP_NOP   = 3'd6,
        OP_HALT  = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        WRITEBACK = 3'd4,
        HALTED    = 3'd5
    } ctrl_state_t;

endpackage

// File: rtl/datapath_controller_if.sv
// Instruction-memory and register-file bus between the controller (master)
// and the memory/register-file side (slave).
interface datapath_controller_if
    import cpu_pkg::*;
#(
    parameter int PC_W    = 4,
    parameter int DATA_W  = ISA_DATA_W,
    parameter int INSTR_W = ISA_INSTR_W
);

    logic [PC_W-1:0]    im_addr;
    logic               im_req;
    logic [INSTR_W-1:0] im_data;
    logic               im_valid;
    logic [2:0]         RF_add1;
    logic [2:0]         RF_add2;
    logic [DATA_W-1:0]  RF_d1;
    logic [DATA_W-1:0]  RF_d2;
    logic [2:0]         RF_wa;
    logic               RF_we;
    logic [DATA_W-1:0]  RF_wd;

    modport master (
        output im_addr, im_req, RF_add1, RF_add2, RF_wa, RF_we, RF_wd,
        input  im_data, im_valid, RF_d1, RF_d2
    );

    modport slave (
        input  im_addr, im_req, RF_add1, RF_add2, RF_wa, RF_we, RF_wd,
        output im_data, im_valid, RF_d1, RF_d2
    );

endinterface

// File: rtl/alu4.sv
// Combinational ALU: result, zero flag and carry/borrow for one instruction.
module alu4
    import cpu_pkg::*;
#(
    parameter int DATA_W = ISA_DATA_W
) (
    input  opcode_t           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [3:0]        i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_zero,
    output logic              o_carry
);

    logic [DATA_W:0] w_sum;

    // Extra top bit of w_sum carries ADD carry-out or SUB borrow.
    always_comb begin
        w_sum = '0;
        case (i_op)
            OP_LOADI: w_sum = {1'b0, DATA_W'(i_imm)};
            OP_ADD:   w_sum = {1'b0, i_a} + {1'b0, i_b};
            OP_SUB:   w_sum = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:   w_sum = {1'b0, i_a & i_b};
            OP_OR:    w_sum = {1'b0, i_a | i_b};
            OP_MOV:   w_sum = {1'b0, i_a};
            default:  w_sum = '0;
        endcase
        o_result = w_sum[DATA_W-1:0];
        o_carry  = w_sum[DATA_W];
        o_zero   = (w_sum[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle fetch/decode/execute/writeback controller driving an 8-entry
// register file; owns pc, IR and the Z/C flags.
module datapath_controller
    import cpu_pkg::*;
#(
    parameter int PC_W    = 4,
    parameter int DATA_W  = ISA_DATA_W,
    parameter int INSTR_W = ISA_INSTR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    datapath_controller_if.master  bus,
    output logic                   halted,
    output logic                   flag_z,
    output logic                   flag_c
);

    if (INSTR_W != ISA_INSTR_W) begin : g_instr_w_check
        $error("datapath_controller: INSTR_W must be 12");
    end

    ctrl_state_t        r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic               r_im_req;
    logic               r_rf_we;
    logic [DATA_W-1:0]  r_wd;
    logic               r_halted;
    logic               r_flag_z;
    logic               r_flag_c;

    opcode_t            w_op;
    logic [DATA_W-1:0]  w_alu_result;
    logic               w_alu_zero;
    logic               w_alu_carry;

    assign w_op = opcode_t'(r_ir[OP_MSB:OP_LSB]);

    alu4 #(.DATA_W(DATA_W)) u_alu (
        .i_op     (w_op),
        .i_a      (bus.RF_d1),
        .i_b      (bus.RF_d2),
        .i_imm    (r_ir[IMM_MSB:IMM_LSB]),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero),
        .o_carry  (w_alu_carry)
    );

    // Controller FSM; every output is a register or a field of IR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_im_req <= 1'b0;
            r_rf_we  <= 1'b0;
            r_wd     <= '0;
            r_halted <= 1'b0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= FETCH;
                        r_im_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus.im_valid) begin
                        r_ir     <= bus.im_data;
                        r_pc     <= r_pc + PC_W'(1);
                        r_im_req <= 1'b0;
                        r_state  <= DECODE;
                    end
                end
                DECODE: begin
                    case (w_op)
                        OP_HALT: begin
                            r_state  <= HALTED;
                            r_halted <= 1'b1;
                        end
                        OP_NOP: begin
                            r_state  <= FETCH;
                            r_im_req <= 1'b1;
                        end
                        default: r_state <= EXECUTE;
                    endcase
                end
                EXECUTE: begin
                    r_wd     <= w_alu_result;
                    r_flag_z <= w_alu_zero;
                    if (w_op == OP_ADD || w_op == OP_SUB) begin
                        r_flag_c <= w_alu_carry;
                    end
                    r_rf_we  <= 1'b1;
                    r_state  <= WRITEBACK;
                end
                WRITEBACK: begin
                    r_rf_we  <= 1'b0;
                    r_im_req <= 1'b1;
                    r_state  <= FETCH;
                end
                HALTED: begin
                    if (start) begin
                        r_halted <= 1'b0;
                        r_im_req <= 1'b1;
                        r_state  <= FETCH;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_im_req <= 1'b0;
                    r_rf_we  <= 1'b0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    // Read addresses come straight from IR, so they are valid from DECODE on.
    assign bus.im_addr = r_pc;
    assign bus.im_req  = r_im_req;
    assign bus.RF_add1 = r_ir[RA_MSB:RA_LSB];
    assign bus.RF_add2 = r_ir[RB_MSB:RB_LSB];
    assign bus.RF_wa   = r_ir[RD_MSB:RD_LSB];
    assign bus.RF_we   = r_rf_we;
    assign bus.RF_wd   = r_wd;
    assign halted      = r_halted;
    assign flag_z      = r_flag_z;
    assign flag_c      = r_flag_c;

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench: instruction memory and register file models, with a
// scoreboard of expected register-file writes.
module tb_datapath_controller;

    logic clk;
    logic reset;
    logic start;
    logic halted;
    logic flag_z;
    logic flag_c;
    logic hold_valid;

    datapath_controller_if #(.PC_W(4), .DATA_W(4), .INSTR_W(12)) bus ();

    datapath_controller #(.PC_W(4), .DATA_W(4), .INSTR_W(12)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bus    (bus),
        .halted (halted),
        .flag_z (flag_z),
        .flag_c (flag_c)
    );

    logic [11:0] imem [16];
    logic [3:0]  rf [8] = '{default: 4'd0};

    assign bus.im_data  = imem[bus.im_addr];
    assign bus.im_valid = bus.im_req & ~hold_valid;
    assign bus.RF_d1    = rf[bus.RF_add1];
    assign bus.RF_d2    = rf[bus.RF_add2];

    // Register file model: synchronous write.
    always @(posedge clk) begin
        if (bus.RF_we) rf[bus.RF_wa] <= bus.RF_wd;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] wa;
        logic [3:0] wd;
        logic       z;
        logic       c;
        logic       gap;
    } exp_t;

    exp_t sb [$];
    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int last_we = 0;
    int nfetch;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] wa, input logic [3:0] wd,
                            input logic z, input logic c, input logic gap);
        exp_t e;
        e.wa = wa; e.wd = wd; e.z = z; e.c = c; e.gap = gap;
        sb.push_back(e);
    endtask

    // Advance one cycle, sample after the edge, score any writeback.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.RF_we) begin
            if (sb.size() == 0) begin
                check_eq("spurious_we", 32'(bus.RF_we), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("wb_wa", 32'(bus.RF_wa), 32'(e.wa));
                check_eq("wb_wd", 32'(bus.RF_wd), 32'(e.wd));
                check_eq("wb_z", 32'(flag_z), 32'(e.z));
                check_eq("wb_c", 32'(flag_c), 32'(e.c));
                if (e.gap) check_eq("we_gap", 32'(cyc - last_we), 32'd4);
                last_we = cyc;
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req"}, 32'(bus.im_req), 32'd0);
        check_eq({tag, "_we"}, 32'(bus.RF_we), 32'd0);
        check_eq({tag, "_addr"}, 32'(bus.im_addr), 32'd0);
        check_eq({tag, "_wa_wd"}, 32'({bus.RF_wa, bus.RF_wd}), 32'd0);
        check_eq({tag, "_add12"}, 32'({bus.RF_add1, bus.RF_add2}), 32'd0);
        check_eq({tag, "_hzc"}, 32'({halted, flag_z, flag_c}), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        hold_valid = 1'b1;
        for (int i = 0; i < 16; i++) imem[i] = 12'hC00;
        imem[0] = 12'h045;
        imem[1] = 12'h08C;
        imem[2] = 12'h2CA;
        imem[3] = 12'h509;
        imem[4] = 12'h541;
        imem[5] = 12'hE00;
        imem[6] = 12'hB98;
        imem[7] = 12'h7D3;
        imem[8] = 12'hE00;

        step();
        check_quiet("reset1");
        step();
        check_quiet("reset2");
        reset = 1'b0;

        push_exp(3'd1, 4'd5,  1'b0, 1'b0, 1'b0);
        push_exp(3'd2, 4'd12, 1'b0, 1'b0, 1'b1);
        push_exp(3'd3, 4'd1,  1'b0, 1'b1, 1'b1);
        push_exp(3'd4, 4'd0,  1'b1, 1'b0, 1'b1);
        push_exp(3'd5, 4'd11, 1'b0, 1'b1, 1'b1);

        // First fetch with im_valid withheld for three cycles.
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("stall_req", 32'(bus.im_req), 32'd1);
            check_eq("stall_addr", 32'(bus.im_addr), 32'd0);
            if (i < 2) step();
        end
        hold_valid = 1'b0;
        step();
        check_eq("post_fetch_req", 32'(bus.im_req), 32'd0);
        check_eq("post_fetch_pc", 32'(bus.im_addr), 32'd1);

        for (int i = 0; i < 60 && !halted; i++) step();
        check_eq("halt1_reached", 32'(halted), 32'd1);
        check_eq("halt1_pc", 32'(bus.im_addr), 32'd6);
        check_eq("halt1_sb_drained", 32'(sb.size()), 32'd0);
        step();
        step();
        check_eq("halt1_hold", 32'({halted, bus.im_req, bus.im_addr}), 32'({1'b1, 1'b0, 4'd6}));

        push_exp(3'd6, 4'd1, 1'b0, 1'b1, 1'b0);
        push_exp(3'd7, 4'd0, 1'b1, 1'b1, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("resume_halted", 32'(halted), 32'd0);
        check_eq("resume_req", 32'(bus.im_req), 32'd1);
        check_eq("resume_addr", 32'(bus.im_addr), 32'd6);
        for (int i = 0; i < 40 && !halted; i++) step();
        check_eq("halt2_reached", 32'(halted), 32'd1);
        check_eq("halt2_pc", 32'(bus.im_addr), 32'd9);
        check_eq("rf_r6", 32'(rf[6]), 32'd1);

        // PC wrap: all NOPs, observe fetch addresses 0..15 then 0.
        reset = 1'b1;
        step();
        check_quiet("reset3");
        for (int i = 0; i < 16; i++) imem[i] = 12'hC00;
        reset = 1'b0;
        start = 1'b1;
        nfetch = 0;
        for (int i = 0; i < 80 && nfetch < 17; i++) begin
            step();
            start = 1'b0;
            if (bus.im_req) begin
                check_eq("wrap_addr", 32'(bus.im_addr), 32'(nfetch % 16));
                nfetch++;
            end
        end
        check_eq("wrap_count", 32'(nfetch), 32'd17);

        // Reset landing on the WRITEBACK cycle.
        reset = 1'b1;
        step();
        imem[0] = 12'h0C7;
        push_exp(3'd3, 4'd7, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 20 && !bus.RF_we; i++) begin
            step();
            start = 1'b0;
        end
        check_eq("wb_reached", 32'(bus.RF_we), 32'd1);
        reset = 1'b1;
        step();
        check_quiet("reset_in_wb");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_eq("idle_after_reset", 32'(bus.im_req), 32'd0);
        check_eq("rf_r3", 32'(rf[3]), 32'd7);
        check_eq("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
